// File: rtl/rr_mux_n.sv
// ---------------------------------------------------------------------------
// rr_mux_n
//   Registered N-input, W-bit multiplexer with per-channel valid/ready
//   handshakes and round-robin arbitration. The block merges several
//   producers onto one consumer through a single output register with
//   valid/ready backpressure. It can move one word per clock.
//
// Parameters
//   N   number of input channels (N >= 2)
//   W   data width per channel (W >= 1)
//   CW  channel index width, $clog2(N) (derived, not overridable)
//
// Ports
//   clk        system clock, rising edge active
//   rst_n      asynchronous active-low reset
//   in_valid   [N]    bit i: channel i presents a word
//   in_data    [N*W]  channel i data at bits [i*W +: W]
//   in_ready   [N]    bit i: channel i word accepted this cycle (combinational)
//   out_valid         output register holds a word
//   out_data   [W]    registered data word
//   out_ch     [CW]   index of the channel that supplied out_data
//   out_ready         consumer accepts out_data this cycle
//
// Optional feature (macro FIXED_SEL_EN)
//   Adds mode_fixed and fixed_sel [CW]. While mode_fixed=1, only channel
//   fixed_sel is eligible and the round-robin pointer does not move.
//   A fixed_sel value >= N grants nothing. With the macro undefined, these
//   ports do not exist and the block is pure round-robin.
// ---------------------------------------------------------------------------
module rr_mux_n #(
    parameter  int N  = 4,
    parameter  int W  = 8,
    localparam int CW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic [CW-1:0]   out_ch,
    input  logic            out_ready
`ifdef FIXED_SEL_EN
    ,
    input  logic            mode_fixed,
    input  logic [CW-1:0]   fixed_sel
`endif
);

    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] grant_idx;
    logic [CW-1:0] ptr_next;
    logic [CW:0]   scan_idx;
    logic [N-1:0]  eligible;
    logic [N-1:0]  grant_oh;
    logic [W-1:0]  sel_data;
    logic          grant_found;
    logic          load;
    logic          xfer;
    logic          ptr_update;

    // Eligibility mask: every requesting channel in round-robin mode, or
    // only the selected channel in fixed mode. The mask is built by
    // comparing against each real index, so fixed_sel >= N matches nothing.
`ifdef FIXED_SEL_EN
    logic [N-1:0] sel_mask;

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < N; i++) begin
            sel_mask[i] = (fixed_sel == CW'(i));
        end
        eligible = mode_fixed ? (in_valid & sel_mask) : in_valid;
    end
`else
    always_comb begin
        eligible = in_valid;
    end
`endif

    // Search starts at rr_ptr and ascends with wrap at N, not at 2^CW.
    // scan_idx is one bit wider than the index, so rr_ptr + k (< 2N) fits
    // before it is folded back into range.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, rr_ptr} + (CW+1)'(k);
            if (scan_idx >= (CW+1)'(N)) begin
                scan_idx = scan_idx - (CW+1)'(N);
            end
            if (!grant_found && eligible[scan_idx[CW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[CW-1:0];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // The output register is free when it is empty or draining this cycle.
    // in_ready is gated with rst_n so no channel sees an accept during reset.
    assign load     = !out_valid || out_ready;
    assign xfer     = rst_n && load && grant_found;
    assign in_ready = xfer ? grant_oh : '0;

    assign sel_data = in_data[int'(grant_idx)*W +: W];
    assign ptr_next = (grant_idx == CW'(N-1)) ? '0 : grant_idx + CW'(1);

`ifdef FIXED_SEL_EN
    assign ptr_update = xfer && !mode_fixed;
`else
    assign ptr_update = xfer;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_ch    <= grant_idx;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (ptr_update) begin
                rr_ptr <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_n.sv
module tb_rr_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [3:0]  iv4, ir4;
    logic [31:0] id4;
    logic        ov4, or4;
    logic [7:0]  od4;
    logic [1:0]  oc4;

    logic [4:0]  iv5, ir5;
    logic [39:0] id5;
    logic        ov5, or5;
    logic [7:0]  od5;
    logic [2:0]  oc5;

`ifdef FIXED_SEL_EN
    logic       mf4, mf5;
    logic [1:0] fs4;
    logic [2:0] fs5;
`endif

    int asserts  = 0;
    int failures = 0;

    rr_mux_n #(.N(4), .W(8)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_data(id4), .in_ready(ir4),
        .out_valid(ov4), .out_data(od4), .out_ch(oc4), .out_ready(or4)
`ifdef FIXED_SEL_EN
        , .mode_fixed(mf4), .fixed_sel(fs4)
`endif
    );

    rr_mux_n #(.N(5), .W(8)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv5), .in_data(id5), .in_ready(ir5),
        .out_valid(ov5), .out_data(od5), .out_ch(oc5), .out_ready(or5)
`ifdef FIXED_SEL_EN
        , .mode_fixed(mf5), .fixed_sel(fs5)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv4 = 4'hF; id4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; or4 = 1'b0;
        iv5 = '0;   id5 = '0; or5 = 1'b0;
`ifdef FIXED_SEL_EN
        mf4 = 1'b0; fs4 = '0; mf5 = 1'b0; fs5 = '0;
`endif
        #1;
        asserts++; if (ov4 !== 1'b0) begin failures++; $display("FAIL reset_ov got %b exp 0", ov4); end
        asserts++; if (od4 !== 8'h00) begin failures++; $display("FAIL reset_od got %h exp 00", od4); end
        asserts++; if (oc4 !== 2'd0) begin failures++; $display("FAIL reset_oc got %0d exp 0", oc4); end
        asserts++; if (ir4 !== 4'b0000) begin failures++; $display("FAIL reset_ir got %b exp 0000", ir4); end
        tick();
        asserts++; if (ir4 !== 4'b0000) begin failures++; $display("FAIL reset_ir_edge got %b exp 0000", ir4); end
        rst_n = 1'b1;
        #1;
        asserts++; if (ir4 !== 4'b0001) begin failures++; $display("FAIL rel_ir got %b exp 0001", ir4); end
        tick();
        asserts++; if (ov4 !== 1'b1 || oc4 !== 2'd0 || od4 !== 8'hA0) begin
            failures++; $display("FAIL first_word got v=%b ch=%0d d=%h exp v=1 ch=0 d=a0", ov4, oc4, od4); end
        // Hold the word under backpressure, then reset between clock edges.
        iv4 = 4'h0;
        #2 rst_n = 1'b0;
        #1;
        asserts++; if (ov4 !== 1'b0 || od4 !== 8'h00 || oc4 !== 2'd0) begin
            failures++; $display("FAIL async_clr got v=%b ch=%0d d=%h exp v=0 ch=0 d=00", ov4, oc4, od4); end
        #2 rst_n = 1'b1;
        iv4 = 4'hF;
        #1;
        asserts++; if (ir4 !== 4'b0001) begin failures++; $display("FAIL rel2_ir got %b exp 0001", ir4); end
        iv4 = 4'h0;
    endtask

    task automatic test_round_robin();
        iv4 = 4'hF; id4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; or4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % 4;
            #1;
            asserts++; if (ir4 !== (4'b0001 << e)) begin
                failures++; $display("FAIL rr_ir[%0d] got %b exp %b", k, ir4, 4'b0001 << e); end
            tick();
            asserts++; if (ov4 !== 1'b1 || oc4 !== 2'(e) || od4 !== 8'(8'hA0 + e)) begin
                failures++; $display("FAIL rr_out[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                                     k, ov4, oc4, od4, e, 8'(8'hA0 + e)); end
        end
        iv4 = 4'h0;
        tick();
        asserts++; if (ov4 !== 1'b0) begin failures++; $display("FAIL rr_drain got %b exp 0", ov4); end
    endtask

    task automatic test_backpressure();
        iv4 = 4'b0100; id4 = {8'h00, 8'h5C, 8'h00, 8'h00}; or4 = 1'b0;
        #1;
        asserts++; if (ir4 !== 4'b0100) begin failures++; $display("FAIL bp_ir0 got %b exp 0100", ir4); end
        tick();
        asserts++; if (ov4 !== 1'b1 || oc4 !== 2'd2 || od4 !== 8'h5C) begin
            failures++; $display("FAIL bp_load got v=%b ch=%0d d=%h exp v=1 ch=2 d=5c", ov4, oc4, od4); end
        id4 = {8'h00, 8'h5D, 8'h00, 8'h00};
        for (int k = 0; k < 3; k++) begin
            #1;
            asserts++; if (ir4 !== 4'b0000) begin failures++; $display("FAIL bp_ir[%0d] got %b exp 0000", k, ir4); end
            tick();
            asserts++; if (ov4 !== 1'b1 || oc4 !== 2'd2 || od4 !== 8'h5C) begin
                failures++; $display("FAIL bp_hold[%0d] got v=%b ch=%0d d=%h exp v=1 ch=2 d=5c", k, ov4, oc4, od4); end
        end
        or4 = 1'b1;
        #1;
        asserts++; if (ir4 !== 4'b0100) begin failures++; $display("FAIL bp_ir_rel got %b exp 0100", ir4); end
        tick();
        asserts++; if (ov4 !== 1'b1 || od4 !== 8'h5D) begin
            failures++; $display("FAIL bp_next got v=%b d=%h exp v=1 d=5d", ov4, od4); end
        iv4 = 4'h0;
        tick();
        asserts++; if (ov4 !== 1'b0) begin failures++; $display("FAIL bp_drain got %b exp 0", ov4); end
        // Pointer must now sit at 3 (after channel 2 was granted twice).
        iv4 = 4'hF;
        #1;
        asserts++; if (ir4 !== 4'b1000) begin failures++; $display("FAIL bp_ptr got %b exp 1000", ir4); end
        iv4 = 4'h0;
    endtask

    task automatic test_sparse_skip();
        or4 = 1'b1;
        id4 = {8'hD3, 8'h11, 8'h22, 8'hD0};
        iv4 = 4'b0001;
        #1;
        asserts++; if (ir4 !== 4'b0001) begin failures++; $display("FAIL sp_wrap_ir got %b exp 0001", ir4); end
        tick();
        asserts++; if (oc4 !== 2'd0 || od4 !== 8'hD0) begin
            failures++; $display("FAIL sp_ch0 got ch=%0d d=%h exp ch=0 d=d0", oc4, od4); end
        iv4 = 4'b1001;
        #1;
        asserts++; if (ir4 !== 4'b1000) begin failures++; $display("FAIL sp_ir3 got %b exp 1000", ir4); end
        tick();
        asserts++; if (oc4 !== 2'd3 || od4 !== 8'hD3) begin
            failures++; $display("FAIL sp_ch3 got ch=%0d d=%h exp ch=3 d=d3", oc4, od4); end
        #1;
        asserts++; if (ir4 !== 4'b0001) begin failures++; $display("FAIL sp_ir0 got %b exp 0001", ir4); end
        tick();
        asserts++; if (oc4 !== 2'd0 || od4 !== 8'hD0 || ov4 !== 1'b1) begin
            failures++; $display("FAIL sp_ch0b got v=%b ch=%0d d=%h exp v=1 ch=0 d=d0", ov4, oc4, od4); end
        iv4 = 4'h0;
        tick();
        asserts++; if (ov4 !== 1'b0) begin failures++; $display("FAIL sp_drain got %b exp 0", ov4); end
    endtask

    task automatic test_non_pow2();
        id5 = {8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0};
        iv5 = 5'h1F; or5 = 1'b1;
        for (int k = 0; k < 11; k++) begin
            int e;
            e = k % 5;
            #1;
            asserts++; if (ir5 !== (5'b00001 << e)) begin
                failures++; $display("FAIL np_ir[%0d] got %b exp %b", k, ir5, 5'b00001 << e); end
            tick();
            asserts++; if (oc5 !== 3'(e) || od5 !== 8'(8'hC0 + e) || ov5 !== 1'b1) begin
                failures++; $display("FAIL np_out[%0d] got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                                     k, ov5, oc5, od5, e, 8'(8'hC0 + e)); end
        end
        iv5 = 5'h0;
        tick();
        asserts++; if (ov5 !== 1'b0) begin failures++; $display("FAIL np_drain got %b exp 0", ov5); end
    endtask

`ifdef FIXED_SEL_EN
    task automatic test_fixed_sel();
        // dut4 pointer is 1 here; fixed-mode grants must not move it.
        id4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        iv4 = 4'hF; or4 = 1'b1; mf4 = 1'b1; fs4 = 2'b10;
        for (int k = 0; k < 3; k++) begin
            #1;
            asserts++; if (ir4 !== 4'b0100) begin failures++; $display("FAIL fx_ir[%0d] got %b exp 0100", k, ir4); end
            tick();
            asserts++; if (oc4 !== 2'd2 || od4 !== 8'hA2) begin
                failures++; $display("FAIL fx_out[%0d] got ch=%0d d=%h exp ch=2 d=a2", k, oc4, od4); end
        end
        mf4 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int e;
            e = k + 1;
            #1;
            asserts++; if (ir4 !== (4'b0001 << e)) begin
                failures++; $display("FAIL fx_rr_ir[%0d] got %b exp %b", k, ir4, 4'b0001 << e); end
            tick();
            asserts++; if (oc4 !== 2'(e)) begin failures++; $display("FAIL fx_rr_ch[%0d] got %0d exp %0d", k, oc4, e); end
        end
        iv4 = 4'h0;
        tick();
        iv5 = 5'h1F; or5 = 1'b1; mf5 = 1'b1; fs5 = 3'd5;
        #1;
        asserts++; if (ir5 !== 5'b00000) begin failures++; $display("FAIL fx_oob_ir got %b exp 00000", ir5); end
        tick();
        asserts++; if (ov5 !== 1'b0) begin failures++; $display("FAIL fx_oob_ov got %b exp 0", ov5); end
        fs5 = 3'd4;
        #1;
        asserts++; if (ir5 !== 5'b10000) begin failures++; $display("FAIL fx_sel4_ir got %b exp 10000", ir5); end
        iv5 = 5'h0; mf5 = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_sparse_skip();
        test_non_pow2();
`ifdef FIXED_SEL_EN
        test_fixed_sel();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
